// File: rtl/fx2fp_scheduler.sv
// Round-robin front end for one shared, clock-enabled fixed-to-float converter.
// A {valid,id} tag pipeline runs alongside the converter so each result leaves
// labelled with the requester that issued it. A stalled output freezes the
// converter and the tag pipeline together, so operands and tags stay aligned.
module fx2fp_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int INT_WID   = 40,
  parameter int FRA_WID   = 40,
  parameter int FLOAT_WID = 80,
  parameter int LAT       = 5,
  parameter int ID_WID    = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*INT_WID-1:0]   req_integer,
  input  logic [NUM_REQ*FRA_WID-1:0]   req_fraction,
  output logic                         conv_clk_en,
  output logic [INT_WID-1:0]           conv_integer,
  output logic [FRA_WID-1:0]           conv_fraction,
  input  logic [FLOAT_WID-1:0]         conv_float_val,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [ID_WID-1:0]            res_id,
  output logic [FLOAT_WID-1:0]         res_float,
  output logic [$clog2(LAT+1)-1:0]     inflight,
  output logic                         busy
);
  localparam int CNT_W = $clog2(LAT+1);

  logic [LAT-1:0]             vld_pipe_q, vld_pipe_d;
  logic [LAT-1:0][ID_WID-1:0] id_pipe_q,  id_pipe_d;
  logic [ID_WID-1:0]          rr_ptr_q,   rr_ptr_d;
  logic                       gnt_vld;
  logic [ID_WID-1:0]          gnt_id;
  logic [ID_WID-1:0]          cand;

  // Only an unaccepted result stalls; bubbles at the head never block.
  assign res_valid   = vld_pipe_q[LAT-1];
  assign res_id      = id_pipe_q[LAT-1];
  assign res_float   = conv_float_val;
  assign conv_clk_en = ~(res_valid & ~res_ready);
  assign busy        = |vld_pipe_q;

  // Round-robin pick: scan from the highest offset down so the lowest
  // offset from rr_ptr wins. No grant while frozen or held in reset.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      cand = ID_WID'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (rstn && conv_clk_en && req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  // Ready, converter operands and pointer advance all follow the grant.
  always_comb begin
    req_ready     = '0;
    conv_integer  = '0;
    conv_fraction = '0;
    rr_ptr_d      = rr_ptr_q;
    if (gnt_vld) begin
      req_ready[gnt_id] = 1'b1;
      conv_integer      = req_integer[gnt_id*INT_WID +: INT_WID];
      conv_fraction     = req_fraction[gnt_id*FRA_WID +: FRA_WID];
      rr_ptr_d          = (gnt_id == ID_WID'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Tag pipeline shifts in lockstep with the converter; bubbles load {0,0}.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    id_pipe_d  = id_pipe_q;
    if (conv_clk_en) begin
      for (int i = LAT-1; i > 0; i--) begin
        vld_pipe_d[i] = vld_pipe_q[i-1];
        id_pipe_d[i]  = id_pipe_q[i-1];
      end
      vld_pipe_d[0] = gnt_vld;
      id_pipe_d[0]  = gnt_vld ? gnt_id : '0;
    end
  end

  // Count of live tags, including the one presented at the output.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + CNT_W'(vld_pipe_q[i]);
  end

  // State registers; reset drops every in-flight tag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
      rr_ptr_q   <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      id_pipe_q  <= id_pipe_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_fx2fp_scheduler.sv
// Directed + random bench for fx2fp_scheduler with a behavioural converter
// (signed 40.40 fixed point to 80-bit extended precision, truncating).
module tb_fx2fp_scheduler;
  localparam int NR = 4, IW = 40, FW = 40, OW = 80, LAT = 5, IDW = 2;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_ready;
  logic [NR*IW-1:0]     req_integer;
  logic [NR*FW-1:0]     req_fraction;
  logic                 conv_clk_en;
  logic [IW-1:0]        conv_integer;
  logic [FW-1:0]        conv_fraction;
  logic [OW-1:0]        conv_float_val;
  logic                 res_valid;
  logic                 res_ready;
  logic [IDW-1:0]       res_id;
  logic [OW-1:0]        res_float;
  logic [2:0]           inflight;
  logic                 busy;

  int n_tests = 0, n_fail = 0;

  fx2fp_scheduler dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_integer(req_integer), .req_fraction(req_fraction),
    .conv_clk_en(conv_clk_en), .conv_integer(conv_integer),
    .conv_fraction(conv_fraction), .conv_float_val(conv_float_val),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_float(res_float), .inflight(inflight), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h @%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [79:0] fx2fp(input logic [39:0] i, input logic [39:0] f);
    logic [79:0] fx, mag;
    int p;
    fx  = {i, f};
    mag = i[39] ? (~fx + 80'd1) : fx;
    if (mag == 80'd0) return 80'd0;
    p = 0;
    for (int b = 0; b < 80; b++) if (mag[b]) p = b;
    mag = mag << (79 - p);
    return {i[39], 15'(16383 + p - 40), mag[79:16]};
  endfunction

  // Behavioural converter: LAT stages, advancing only on conv_clk_en.
  logic [OW-1:0] cv_pipe [LAT];
  always @(posedge clk) begin
    if (conv_clk_en) begin
      cv_pipe[0] <= fx2fp(conv_integer, conv_fraction);
      for (int i = 1; i < LAT; i++) cv_pipe[i] <= cv_pipe[i-1];
    end
  end
  assign conv_float_val = cv_pipe[LAT-1];

  // Scoreboard and round-robin reference, sampled mid-cycle.
  typedef struct { int id; logic [79:0] f; } sb_t;
  sb_t          sb[$];
  sb_t          e;
  int           m_ptr = 0;
  int           g, idx;
  logic [NR-1:0] exp_rdy;
  logic         en_exp;

  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      sb.delete();
      m_ptr = 0;
    end
    en_exp = !(res_valid && !res_ready);
    chk("clk_en", 80'(conv_clk_en), 80'(en_exp));
    chk("inflight", 80'(inflight), 80'(sb.size()));
    chk("busy", 80'(busy), 80'(inflight != 3'd0));
    g = -1;
    if (rstn && en_exp)
      for (int k = 0; k < NR; k++) begin
        idx = (m_ptr + k) % NR;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 80'(req_ready), 80'(exp_rdy));
    chk("conv_int", 80'(conv_integer), (g >= 0) ? 80'(req_integer[g*IW +: IW]) : 80'd0);
    chk("conv_frac", 80'(conv_fraction), (g >= 0) ? 80'(req_fraction[g*FW +: FW]) : 80'd0);
    if (rstn && res_valid && res_ready) begin
      if (sb.size() == 0) chk("sb_unexpected", 80'(res_id), 80'hDEAD);
      else begin
        e = sb.pop_front();
        chk("res_id", 80'(res_id), 80'(e.id));
        chk("res_float", res_float, e.f);
      end
    end
    if (g >= 0) begin
      e.id = g;
      e.f  = fx2fp(req_integer[g*IW +: IW], req_fraction[g*FW +: FW]);
      sb.push_back(e);
      m_ptr = (g + 1) % NR;
    end
  end

  task automatic tick();  @(posedge clk); #1; endtask
  task automatic probe(); @(negedge clk); #1; endtask

  task automatic set_op(input int r, input logic [39:0] iv, input logic [39:0] fv);
    req_integer[r*IW +: IW]  = iv;
    req_fraction[r*FW +: FW] = fv;
  endtask

  task automatic drain();
    req_valid = '0;
    res_ready = 1'b1;
    for (int n = 0; n < 30; n++) begin
      tick(); probe();
      if (inflight == 3'd0) break;
    end
    chk("drain", 80'(inflight), 80'd0);
  endtask

  int hits, at_n;
  logic [IDW-1:0] hit_id, id0;
  logic [OW-1:0]  hit_f, f0;
  logic [63:0]    r1, r2;

  initial begin
    rstn = 1'b0; req_valid = 4'hF; res_ready = 1'b1;
    req_integer = '0; req_fraction = '0;
    for (int r = 0; r < NR; r++) set_op(r, 40'(r * 3 + 7), 40'(r + 1) << 20);
    probe();
    chk("rst_ready", 80'(req_ready), 80'd0);
    chk("rst_res_valid", 80'(res_valid), 80'd0);
    chk("rst_res_id", 80'(res_id), 80'd0);
    chk("rst_inflight", 80'(inflight), 80'd0);
    chk("rst_busy", 80'(busy), 80'd0);
    chk("rst_clk_en", 80'(conv_clk_en), 80'd1);
    chk("rst_conv_int", 80'(conv_integer), 80'd0);
    tick(); rstn = 1'b1; req_valid = '0;

    // Single request from requester 2: 1.0 -> 3FFF8000...
    tick(); req_valid = 4'b0100; set_op(2, 40'd1, 40'd0);
    probe(); chk("single_gnt", 80'(req_ready), 80'b0100);
    tick(); req_valid = '0;
    hits = 0; at_n = 0; hit_id = '0; hit_f = '0;
    for (int n = 1; n <= 8; n++) begin
      probe();
      if (res_valid) begin hits++; at_n = n; hit_id = res_id; hit_f = res_float; end
      tick();
    end
    chk("single_pulses", 80'(hits), 80'd1);
    chk("single_lat", 80'(at_n), 80'd5);
    chk("single_id", 80'(hit_id), 80'd2);
    chk("single_float", hit_f, 80'h3FFF8000000000000000);

    // Restart from reset; all requesters valid -> 0,1,2,3,... one per cycle.
    rstn = 1'b0; probe(); tick(); rstn = 1'b1;
    for (int r = 0; r < NR; r++) set_op(r, -40'(r + 2), 40'h8000000000 >> r);
    req_valid = 4'hF;
    for (int k = 0; k < 12; k++) begin
      probe();
      chk("rr_order", 80'(req_ready), 80'(4'b0001 << (k % 4)));
      if (k >= 5) begin
        chk("full_inflight", 80'(inflight), 80'd5);
        chk("full_res_id", 80'(res_id), 80'((k - 5) % 4));
      end
      tick();
    end

    // Backpressure with a full pipeline.
    res_ready = 1'b0;
    probe(); id0 = res_id; f0 = res_float;
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid", 80'(res_valid), 80'd1);
      chk("bp_id", 80'(res_id), 80'(id0));
      chk("bp_float", res_float, f0);
      chk("bp_ready", 80'(req_ready), 80'd0);
      tick(); probe();
    end
    tick(); res_ready = 1'b1;
    drain();
    chk("bp_sb_empty", 80'(sb.size()), 80'd0);

    // rr_ptr=3 with only 1 and 3 valid -> 3 then 1.
    tick(); req_valid = 4'b0100;
    probe(); chk("ptr_setup", 80'(req_ready), 80'b0100);
    tick(); req_valid = 4'b1010;
    probe(); chk("wrap_first", 80'(req_ready), 80'b1000);
    tick();
    probe(); chk("wrap_second", 80'(req_ready), 80'b0010);
    tick();
    drain();

    // Reset with three tags in flight.
    tick(); req_valid = 4'b0001;
    probe(); tick(); probe(); tick(); probe(); tick();
    req_valid = '0;
    probe(); chk("pre_rst_inflight", 80'(inflight), 80'd3);
    rstn = 1'b0; req_valid = 4'b1010;
    #1;
    chk("mid_rst_valid", 80'(res_valid), 80'd0);
    chk("mid_rst_inflight", 80'(inflight), 80'd0);
    chk("mid_rst_busy", 80'(busy), 80'd0);
    probe();
    tick(); rstn = 1'b1;
    probe(); chk("post_rst_gnt", 80'(req_ready), 80'b0010);
    tick(); req_valid = '0;
    drain();

    // Random traffic; the scoreboard checks order, id and value.
    for (int c = 0; c < 10000; c++) begin
      tick();
      req_valid = 4'($urandom);
      res_ready = ($urandom % 4) != 0;
      for (int r = 0; r < NR; r++) begin
        r1 = {$urandom, $urandom}; r2 = {$urandom, $urandom};
        set_op(r, (c % 17 == 0) ? 40'd0 : r1[39:0], r2[39:0]);
      end
    end
    tick();
    drain();
    chk("final_sb_empty", 80'(sb.size()), 80'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule

// File: doc/fx2fp_scheduler.md
FX2FP_SCHEDULER -- requirements
Module: fx2fp_scheduler

Interface
REQ-001 Parameters SHALL be:
- NUM_REQ, 4, number of requesters (2..8).
- INT_WID, 40, integer operand width.
- FRA_WID, 40, fraction operand width.
- FLOAT_WID, 80, converter result width.
- LAT, 5, converter latency in clk_en-qualified cycles.
- ID_WID, $clog2(NUM_REQ), requester tag width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rstn, in, 1, asynchronous active-low reset.
- req_valid, in, NUM_REQ, per-requester operand valid.
- req_ready, out, NUM_REQ, per-requester accept.
- req_integer, in, NUM_REQ*INT_WID, signed integer operands; requester i occupies slice i.
- req_fraction, in, NUM_REQ*FRA_WID, fraction operands; requester i occupies slice i.
- conv_clk_en, out, 1, clock enable to the shared converter.
- conv_integer, out, INT_WID, operand to the converter.
- conv_fraction, out, FRA_WID, operand to the converter.
- conv_float_val, in, FLOAT_WID, converter result.
- res_valid, out, 1, result valid.
- res_ready, in, 1, result accept.
- res_id, out, ID_WID, requester that owns the result.
- res_float, out, FLOAT_WID, result value (= conv_float_val).
- inflight, out, $clog2(LAT+1), number of valid tags in the pipeline.
- busy, out, 1, high when inflight != 0.

Function
REQ-003 Clock and reset: the block SHALL use one clock, clk. Reset SHALL be asynchronous and active-low on rstn.
REQ-004 conv_clk_en SHALL be driven combinationally as NOT(res_valid AND NOT res_ready). The pipeline therefore freezes only while a presented result is not accepted.
REQ-005 The block SHALL hold a tag pipeline of LAT entries, each {valid, id}. It SHALL shift one position on every clk edge where conv_clk_en=1 and SHALL hold otherwise.
REQ-006 Entry 0 SHALL load {1, granted id} on a grant and {0, 0} when there is no grant. res_valid/res_id SHALL be entry LAT-1.
REQ-007 Grant rule: a grant SHALL occur only when conv_clk_en=1 and at least one req_valid is set. Selection SHALL be round-robin: the lowest index at or after rr_ptr, wrapping modulo NUM_REQ.
REQ-008 req_ready SHALL be one-hot of the granted requester, or all zero. A transfer on requester i SHALL be req_valid[i] AND req_ready[i]. A requester never sees ready while the pipeline is frozen.
REQ-009 rr_ptr SHALL update on a grant to (granted+1) mod NUM_REQ, and SHALL hold otherwise. A grant to NUM_REQ-1 SHALL wrap rr_ptr to 0.
REQ-010 conv_integer/conv_fraction SHALL equal the granted requester's slice in the grant cycle. With no grant they SHALL be 0, so the inserted bubble converts zero.
REQ-011 Latency: an operand granted at edge t SHALL appear as res_valid=1 with its id after LAT enabled edges. With no stalls this is exactly LAT cycles.
REQ-012 Results SHALL be returned in grant order. No result may be dropped or duplicated under any res_ready pattern.
REQ-013 Simultaneous events: in a cycle where res_ready=1 and res_valid=1, the result SHALL be consumed, the pipeline SHALL advance, and a new grant SHALL be allowed in that same cycle. Throughput SHALL be one operand per cycle.
REQ-014 inflight SHALL be the count of valid tag entries, updated each edge, with range 0..LAT. busy SHALL equal (inflight != 0).
REQ-015 Bubbles SHALL occupy pipeline slots normally. They SHALL NOT raise res_valid and SHALL NOT be squeezed out.
REQ-016 A requester that drops req_valid without a transfer SHALL lose nothing and SHALL NOT stall other requesters.

Reset
REQ-017 While rstn=0, all of the following SHALL be 0:
- tag entries;
- rr_ptr;
- res_valid, res_id, inflight, busy;
- req_ready.
In addition, conv_clk_en SHALL be 1 and conv operands SHALL be 0.
REQ-018 Reset asserted mid-operation SHALL discard all in-flight tags. The first grant after release SHALL go to the lowest-index valid requester.

Verification
REQ-019 Single request: req 2 sends integer=1, fraction=0, res_ready=1 -> exactly 5 cycles later a single res_valid pulse, with res_id=2 and res_float=0x3FFF8000000000000000.
REQ-020 All 4 requesters continuously valid, res_ready=1 -> grant order 0,1,2,3,0,1… with one grant per cycle. Results return with res_id in the same order and inflight=5 in steady state.
REQ-021 Backpressure: hold res_ready=0 for 10 cycles with the pipeline full -> res_valid stays 1, res_id and res_float stay stable, req_ready=0 throughout, and no result is lost after release.
REQ-022 rr_ptr=3 and only reqs 1 and 3 valid -> req 3 is granted, then req 1.
REQ-023 Assert rstn low with inflight=3 -> res_valid=0 and inflight=0 immediately. After release, no stale results appear.
REQ-024 Random valid/ready stimulus for 10k cycles -> the scoreboard shows every accepted operand returned once, in order, with the correct id.
